// File: rtl/gpio_ctrl_pkg.sv
// Shared definitions for the GPIO peripheral: pi1 bus op codes, register
// offsets and the debounce prescaler sizing helper.
package gpio_ctrl_pkg;

    localparam logic [1:0] PINOOP = 2'b00;
    localparam logic [1:0] PIWROP = 2'b01;
    localparam logic [1:0] PIRDOP = 2'b10;
    localparam logic [1:0] PIRWOP = 2'b11;

    localparam logic [3:0] GPIO_REG_IN     = 4'd0;
    localparam logic [3:0] GPIO_REG_OUT    = 4'd1;
    localparam logic [3:0] GPIO_REG_DIR    = 4'd2;
    localparam logic [3:0] GPIO_REG_SET    = 4'd3;
    localparam logic [3:0] GPIO_REG_CLR    = 4'd4;
    localparam logic [3:0] GPIO_REG_TGL    = 4'd5;
    localparam logic [3:0] GPIO_REG_RISEEN = 4'd6;
    localparam logic [3:0] GPIO_REG_FALLEN = 4'd7;
    localparam logic [3:0] GPIO_REG_STATUS = 4'd8;

    localparam int GPIO_MAPSZ = 16;

    // A prescaler always needs at least one bit, even for a period of 1.
    function automatic int prescale_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/gpio_insync.sv
// Pad input conditioning: a multi-flop synchroniser per pin followed by an
// optional debounce that shares one prescaler across all pins.
module gpio_insync
    import gpio_ctrl_pkg::*;
#(
    parameter int GPIO_COUNT     = 1,
    parameter int SYNCSTAGES     = 2,
    parameter int DEBOUNCECYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [GPIO_COUNT-1:0] raw,
    output logic [GPIO_COUNT-1:0] in_val
);

    logic [SYNCSTAGES-1:0][GPIO_COUNT-1:0] sync_reg;
    logic [GPIO_COUNT-1:0]                 synced;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNCSTAGES-2:0], raw};
        end
    end

    assign synced = sync_reg[SYNCSTAGES-1];

    generate
        if (DEBOUNCECYCLES == 0) begin : g_nodb
            assign in_val = synced;
        end else begin : g_db
            localparam int PW = prescale_width(DEBOUNCECYCLES);

            logic [PW-1:0]         presc_reg;
            logic [GPIO_COUNT-1:0] sample_reg;
            logic [GPIO_COUNT-1:0] in_reg;
            logic [GPIO_COUNT-1:0] agree;
            logic                  tick;

            assign tick  = (presc_reg == PW'(DEBOUNCECYCLES - 1));
            // A bit is accepted only when this tick's sample matches the previous one.
            assign agree = ~(sample_reg ^ synced);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    presc_reg  <= '0;
                    sample_reg <= '0;
                    in_reg     <= '0;
                end else begin
                    presc_reg <= tick ? '0 : presc_reg + PW'(1);
                    if (tick) begin
                        sample_reg <= synced;
                        in_reg     <= (in_reg & ~agree) | (synced & agree);
                    end
                end
            end

            assign in_val = in_reg;
        end
    endgenerate

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO peripheral on the pi1 bus: direction/output registers with atomic
// set/clear/toggle, conditioned inputs and W1C edge interrupt status.
module gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int  ARCHBITSZ      = 32,
    parameter int  GPIO_COUNT     = 1,
    parameter int  SYNCSTAGES     = 2,
    parameter int  DEBOUNCECYCLES = 0,
    localparam int ADDRBITSZ      = ARCHBITSZ - $clog2(ARCHBITSZ / 8)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             pi1_op_i,
    input  logic [ADDRBITSZ-1:0]   pi1_addr_i,
    input  logic [ARCHBITSZ-1:0]   pi1_data_i,
    output logic [ARCHBITSZ-1:0]   pi1_data_o,
    input  logic [ARCHBITSZ/8-1:0] pi1_sel_i,
    output logic                   pi1_rdy_o,
    output logic [ADDRBITSZ-1:0]   pi1_mapsz_o,
    input  logic [GPIO_COUNT-1:0]  gp_i,
    output logic [GPIO_COUNT-1:0]  gp_o,
    output logic [GPIO_COUNT-1:0]  gp_oe_o,
    output logic                   irq_o
);

    localparam int NBYTES = ARCHBITSZ / 8;

    logic [ARCHBITSZ-1:0]  byte_mask;
    logic [ARCHBITSZ-1:0]  rd_val;
    logic [GPIO_COUNT-1:0] reg_val;
    logic [GPIO_COUNT-1:0] wr_be, wr_mask;
    logic [GPIO_COUNT-1:0] in_val, prev_in_reg;
    logic [GPIO_COUNT-1:0] out_reg, dir_reg, rise_en_reg, fall_en_reg, status_reg;
    logic [GPIO_COUNT-1:0] status_set, status_clr;
    logic [ARCHBITSZ-1:0]  data_reg;
    logic                  irq_reg;
    logic [3:0]            reg_sel;
    logic                  do_wr, do_rd;
    logic                  unused_bits;

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_be
            assign byte_mask[gi*8 +: 8] = {8{pi1_sel_i[gi]}};
        end
    endgenerate

    assign reg_sel     = pi1_addr_i[3:0];
    assign do_wr       = (pi1_op_i == PIWROP) || (pi1_op_i == PIRWOP);
    assign do_rd       = (pi1_op_i == PIRDOP) || (pi1_op_i == PIRWOP);
    assign wr_be       = byte_mask[GPIO_COUNT-1:0];
    assign wr_mask     = pi1_data_i[GPIO_COUNT-1:0] & wr_be;
    assign unused_bits = ^{pi1_addr_i, pi1_data_i, byte_mask};

    gpio_insync #(
        .GPIO_COUNT    (GPIO_COUNT),
        .SYNCSTAGES    (SYNCSTAGES),
        .DEBOUNCECYCLES(DEBOUNCECYCLES)
    ) u_insync (
        .clk   (clk_i),
        .rst_n (rst_i),
        .raw   (gp_i),
        .in_val(in_val)
    );

    // Edges are taken on the conditioned input regardless of DIR, so driven pins loop back.
    assign status_set = (in_val & ~prev_in_reg & rise_en_reg) | (~in_val & prev_in_reg & fall_en_reg);
    assign status_clr = (do_wr && reg_sel == GPIO_REG_STATUS) ? wr_mask : '0;

    always_comb begin
        reg_val = '0;
        case (reg_sel)
            GPIO_REG_IN:     reg_val = in_val;
            GPIO_REG_OUT:    reg_val = out_reg;
            GPIO_REG_DIR:    reg_val = dir_reg;
            GPIO_REG_RISEEN: reg_val = rise_en_reg;
            GPIO_REG_FALLEN: reg_val = fall_en_reg;
            GPIO_REG_STATUS: reg_val = status_reg;
            default:         reg_val = '0;
        endcase
        rd_val = '0;
        rd_val[GPIO_COUNT-1:0] = reg_val;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_reg     <= '0;
            dir_reg     <= '0;
            rise_en_reg <= '0;
            fall_en_reg <= '0;
            status_reg  <= '0;
            prev_in_reg <= '0;
            data_reg    <= '0;
            irq_reg     <= 1'b0;
        end else begin
            prev_in_reg <= in_val;
            irq_reg     <= |status_reg;
            // Set after clear so a new edge beats a simultaneous W1C.
            status_reg  <= (status_reg & ~status_clr) | status_set;
            if (do_rd) begin
                data_reg <= rd_val;
            end
            if (do_wr) begin
                case (reg_sel)
                    GPIO_REG_OUT:    out_reg     <= (out_reg & ~wr_be) | wr_mask;
                    GPIO_REG_DIR:    dir_reg     <= (dir_reg & ~wr_be) | wr_mask;
                    GPIO_REG_SET:    out_reg     <= out_reg | wr_mask;
                    GPIO_REG_CLR:    out_reg     <= out_reg & ~wr_mask;
                    GPIO_REG_TGL:    out_reg     <= out_reg ^ wr_mask;
                    GPIO_REG_RISEEN: rise_en_reg <= (rise_en_reg & ~wr_be) | wr_mask;
                    GPIO_REG_FALLEN: fall_en_reg <= (fall_en_reg & ~wr_be) | wr_mask;
                    default: ;
                endcase
            end
        end
    end

    assign pi1_data_o  = data_reg;
    assign pi1_rdy_o   = 1'b1;
    assign pi1_mapsz_o = ADDRBITSZ'(GPIO_MAPSZ);
    assign gp_o        = out_reg;
    assign gp_oe_o     = dir_reg;
    assign irq_o       = irq_reg;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Bench for gpio_ctrl: an 8-pin undebounced instance and a 32-pin debounced
// instance; read data is checked by a queue-driven monitor.
module tb_gpio_ctrl;
    import gpio_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [1:0]  op8, op32;
    logic [29:0] addr8, addr32, map8, map32;
    logic [31:0] wd8, wd32, rd8, rd32;
    logic [3:0]  sel8, sel32;
    logic        rdy8, rdy32, irq8, irq32;
    logic [7:0]  gpi8, gpo8, oe8;
    logic [31:0] gpi32, gpo32, oe32;

    gpio_ctrl #(.ARCHBITSZ(32), .GPIO_COUNT(8), .SYNCSTAGES(2), .DEBOUNCECYCLES(0)) dut8 (
        .clk_i(clk), .rst_i(rst_n), .pi1_op_i(op8), .pi1_addr_i(addr8), .pi1_data_i(wd8),
        .pi1_data_o(rd8), .pi1_sel_i(sel8), .pi1_rdy_o(rdy8), .pi1_mapsz_o(map8),
        .gp_i(gpi8), .gp_o(gpo8), .gp_oe_o(oe8), .irq_o(irq8)
    );

    gpio_ctrl #(.ARCHBITSZ(32), .GPIO_COUNT(32), .SYNCSTAGES(2), .DEBOUNCECYCLES(4)) dut32 (
        .clk_i(clk), .rst_i(rst_n), .pi1_op_i(op32), .pi1_addr_i(addr32), .pi1_data_i(wd32),
        .pi1_data_o(rd32), .pi1_sel_i(sel32), .pi1_rdy_o(rdy32), .pi1_mapsz_o(map32),
        .gp_i(gpi32), .gp_o(gpo32), .gp_oe_o(oe32), .irq_o(irq32)
    );

    typedef struct {
        string       nm;
        logic [31:0] exp;
    } exp_t;

    exp_t q8[$];
    exp_t q32[$];
    int   total = 0;
    int   bad   = 0;
    logic rdv8  = 1'b0;
    logic rdv32 = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    // A read issued at one posedge presents its data by the following negedge.
    always @(posedge clk) begin
        rdv8  <= op8[1];
        rdv32 <= op32[1];
    end

    always @(negedge clk) begin
        if (rdv8) begin
            exp_t e;
            if (q8.size() == 0) begin
                total++; bad++;
                $display("FAIL rd8_unexpected: got %h expected none", rd8);
            end else begin
                e = q8.pop_front();
                check(e.nm, rd8, e.exp);
            end
        end
        if (rdv32) begin
            exp_t e;
            if (q32.size() == 0) begin
                total++; bad++;
                $display("FAIL rd32_unexpected: got %h expected none", rd32);
            end else begin
                e = q32.pop_front();
                check(e.nm, rd32, e.exp);
            end
        end
    end

    task automatic bus(input bit big, input logic [1:0] op, input logic [3:0] off,
                       input logic [31:0] wd, input logic [3:0] sel,
                       input logic [31:0] exp, input string nm);
        exp_t e;
        @(negedge clk);
        e.nm  = nm;
        e.exp = exp;
        if (big) begin
            op32 = op; addr32 = {26'd0, off}; wd32 = wd; sel32 = sel;
            if (op[1]) q32.push_back(e);
        end else begin
            op8 = op; addr8 = {26'd0, off}; wd8 = wd; sel8 = sel;
            if (op[1]) q8.push_back(e);
        end
        @(negedge clk);
        op8  = PINOOP;
        op32 = PINOOP;
    endtask

    task automatic wr(input bit big, input logic [3:0] off, input logic [31:0] wd);
        bus(big, PIWROP, off, wd, 4'hF, 32'd0, "");
    endtask

    task automatic rd(input bit big, input logic [3:0] off, input logic [31:0] exp, input string nm);
        bus(big, PIRDOP, off, 32'd0, 4'hF, exp, nm);
    endtask

    initial begin
        rst_n = 1'b0;
        op8 = PINOOP; addr8 = '0; wd8 = '0; sel8 = '0; gpi8 = '0;
        op32 = PINOOP; addr32 = '0; wd32 = '0; sel32 = '0; gpi32 = '0;
        repeat (3) @(negedge clk);
        check("rst_gp_o", {24'd0, gpo8}, 32'h0);
        check("rst_gp_oe", {24'd0, oe8}, 32'h0);
        check("rst_irq", {31'd0, irq8}, 32'h0);
        check("rst_data", rd8, 32'h0);
        rst_n = 1'b1;
        check("rdy", {31'd0, rdy8}, 32'h1);
        check("mapsz", {2'd0, map8}, 32'd16);

        // Output path and atomic bit operations
        wr(0, GPIO_REG_DIR, 32'hFF);
        check("dir_oe", {24'd0, oe8}, 32'hFF);
        wr(0, GPIO_REG_OUT, 32'hA5);
        check("out_wr", {24'd0, gpo8}, 32'hA5);
        wr(0, GPIO_REG_SET, 32'h0A);
        check("out_set", {24'd0, gpo8}, 32'hAF);
        wr(0, GPIO_REG_CLR, 32'h80);
        check("out_clr", {24'd0, gpo8}, 32'h2F);
        wr(0, GPIO_REG_TGL, 32'h03);
        check("out_tgl", {24'd0, gpo8}, 32'h2C);
        rd(0, GPIO_REG_OUT, 32'h2C, "rd_out");
        rd(0, GPIO_REG_SET, 32'h0, "rd_set_wo");
        bus(0, PIWROP, GPIO_REG_OUT, 32'h77, 4'h0, 32'd0, "");
        check("sel0_ignored", {24'd0, gpo8}, 32'h2C);
        bus(0, PIRWOP, GPIO_REG_OUT, 32'hFFFFFF5A, 4'hF, 32'h2C, "rw_out_swap");
        check("rw_out_new", {24'd0, gpo8}, 32'h5A);
        rd(0, GPIO_REG_OUT, 32'h5A, "rd_out_trunc");
        rd(0, 4'd12, 32'h0, "rd_unmapped8");

        // Edge interrupts
        wr(0, GPIO_REG_RISEEN, 32'h01);
        wr(0, GPIO_REG_FALLEN, 32'h02);
        @(negedge clk);
        gpi8 = 8'h03;
        repeat (3) @(negedge clk);
        check("irq_lag", {31'd0, irq8}, 32'h0);
        @(negedge clk);
        check("irq_set", {31'd0, irq8}, 32'h1);
        rd(0, GPIO_REG_STATUS, 32'h01, "status_rise");
        gpi8 = 8'h00;
        repeat (4) @(negedge clk);
        rd(0, GPIO_REG_STATUS, 32'h03, "status_fall");
        wr(0, GPIO_REG_STATUS, 32'h01);
        rd(0, GPIO_REG_STATUS, 32'h02, "status_w1c");
        bus(0, PIRWOP, GPIO_REG_STATUS, 32'h02, 4'hF, 32'h02, "status_rw");
        check("irq_hold_1cyc", {31'd0, irq8}, 32'h1);
        @(negedge clk);
        check("irq_fall", {31'd0, irq8}, 32'h0);

        // New rising edge lands in the same cycle as a W1C of that bit
        gpi8 = 8'h01;
        repeat (5) @(negedge clk);
        gpi8 = 8'h00;
        repeat (5) @(negedge clk);
        gpi8 = 8'h01;
        @(negedge clk);
        wr(0, GPIO_REG_STATUS, 32'h01);
        rd(0, GPIO_REG_STATUS, 32'h01, "status_set_wins");
        check("irq_stays", {31'd0, irq8}, 32'h1);

        // Asynchronous reset between edges during a write
        @(negedge clk);
        op8 = PIWROP; addr8 = {26'd0, GPIO_REG_DIR}; wd8 = 32'h0F; sel8 = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        check("arst_gp_o", {24'd0, gpo8}, 32'h0);
        check("arst_gp_oe", {24'd0, oe8}, 32'h0);
        check("arst_irq", {31'd0, irq8}, 32'h0);
        @(negedge clk);
        op8 = PINOOP;
        @(negedge clk);
        rst_n = 1'b1;
        rd(0, GPIO_REG_OUT, 32'h0, "post_rst_out");
        rd(0, GPIO_REG_DIR, 32'h0, "post_rst_dir");

        // Byte enables on the full-width instance
        bus(1, PIWROP, GPIO_REG_OUT, 32'h11223344, 4'b0101, 32'd0, "");
        rd(1, GPIO_REG_OUT, 32'h00220044, "be_out");
        check("be_gp_o", gpo32, 32'h00220044);
        rd(1, 4'd12, 32'h0, "rd_unmapped32");

        // Debounce: a one-cycle glitch is rejected, a stable level is accepted once
        wr(1, GPIO_REG_RISEEN, 32'h1);
        @(negedge clk);
        gpi32 = 32'h1;
        @(negedge clk);
        gpi32 = 32'h0;
        repeat (12) @(negedge clk);
        rd(1, GPIO_REG_IN, 32'h0, "db_glitch_in");
        rd(1, GPIO_REG_STATUS, 32'h0, "db_glitch_status");
        gpi32 = 32'h1;
        repeat (12) @(negedge clk);
        rd(1, GPIO_REG_IN, 32'h1, "db_stable_in");
        rd(1, GPIO_REG_STATUS, 32'h1, "db_stable_status");
        check("db_irq", {31'd0, irq32}, 32'h1);
        wr(1, GPIO_REG_STATUS, 32'h1);
        repeat (16) @(negedge clk);
        rd(1, GPIO_REG_STATUS, 32'h0, "db_set_once");
        check("db_irq_clear", {31'd0, irq32}, 32'h0);

        repeat (3) @(negedge clk);
        if (q8.size() != 0 || q32.size() != 0) begin
            total++; bad++;
            $display("FAIL pending_reads: got %0d/%0d expected 0/0", q8.size(), q32.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
